// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among NREQ producers.
// Build option FIFO_ARB_BURST_LOCK_EN: a tenure lasts up to BURST beats instead of one.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    fifo_wr_en,
    output logic [DW-1:0]           fifo_data,
    input  logic                    fifo_full,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);
    // state | meaning
    // IDLE  | no grant; arbitrate among pending requests
    // GRANT | owner holds the tenure
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [OW-1:0] rr_sel, rr_idx;
    logic          rr_found;
    logic          own_req, accept, last_beat;
    logic [DW-1:0] own_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // First requester found searching upward from last_q+1, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = last_q;
        rr_idx   = last_q;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = OW'((int'(last_q) + i) % NREQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_req  = req[i];
                own_data = req_data[i*DW +: DW];
            end
        end
    end

`ifdef FIFO_ARB_BURST_LOCK_EN
    assign last_beat = (beat_q == CW'(BURST - 1));
`else
    assign last_beat = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        beat_d     = beat_q;
        gnt        = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    owner_d = rr_sel;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                fifo_data = own_data;
                accept    = own_req & ~fifo_full;
                for (int i = 0; i < NREQ; i++) begin
                    if (owner_q == OW'(i)) gnt[i] = accept;
                end
                fifo_wr_en = |(req & gnt);
                if (accept) beat_d = beat_q + CW'(1);
                // A dropped request ends the tenure even while the FIFO is full.
                if (!own_req || (accept && last_beat)) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign owner = owner_q;
    assign busy  = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle vector table, streaming sequences
// and a FIFO-fill sequence, with a write scoreboard checked on every fifo_wr_en.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam int TEN = BURST;
    localparam int FS_LEN = 9;
    localparam logic [10:0] FS_FULL = 11'h038;
    localparam logic [10:0] FS_GNT  = 11'h0C6;
    localparam logic [10:0] FS_BUSY = 11'h0FE;
`else
    localparam int TEN = 1;
    localparam int FS_LEN = 11;
    localparam logic [10:0] FS_FULL = 11'h070;
    localparam logic [10:0] FS_GNT  = 11'h28A;
    localparam logic [10:0] FS_BUSY = 11'h2EA;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data;
    logic        fifo_full;
    logic [1:0]  owner;
    logic        busy;

    logic        full_force;
    logic        fifo_clr;
    int          fcnt;
    int          errors = 0;
    int          checks = 0;

    typedef struct {int who; logic [7:0] data;} beat_t;
    beat_t exp_q[$];
    beat_t mon_e;
    int    mon_who;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic       wr;
        logic       busy;
        logic [1:0] own;
        logic [7:0] data;
    } vec_t;
    vec_t vt[$];

    logic [3:0] acc;
    int         sent[4];

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .owner      (owner),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign fifo_full = full_force | (fcnt >= 64);

    // 64-deep FIFO occupancy, never read.
    always @(posedge clk) begin
        if (fifo_clr) fcnt <= 0;
        else if (reset_n && fifo_wr_en) fcnt <= fcnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write seen before its edge must match the next expected beat.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            mon_who = -1;
            for (int i = 0; i < 4; i++) if (gnt[i]) mon_who = i;
            check("write_while_full", 32'(fifo_full), 32'h0);
            check("write_outside_grant", 32'(busy), 32'h1);
            check("write_expected", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("write_requester", 32'(mon_who), 32'(mon_e.who));
                check("write_data", 32'(fifo_data), 32'(mon_e.data));
            end
        end
    end

    function automatic logic [7:0] dval(input int i, input int k);
        return 8'(i * 64 + 1 + k);
    endfunction

    function automatic void add(input logic rst, input logic [3:0] r, input logic f,
                                input logic [3:0] g, input logic w, input logic b,
                                input logic [1:0] o, input logic [7:0] d);
        vt.push_back('{rst, r, f, g, w, b, o, d});
    endfunction

    task automatic adv();
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) sent[i]++;
            req_data[i*8 +: 8] = dval(i, sent[i]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; req = '0; full_force = 1'b0; fifo_clr = 1'b1; acc = '0;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1; fifo_clr = 1'b0;
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
    endtask

    task automatic run_stream(input logic [3:0] mask, input int tenures, input string tag);
        int ord[$];
        int es[4];
        int o, last, beats, total, j, eg;
        do_reset();
        last = 3;
        for (int i = 0; i < 4; i++) es[i] = 0;
        for (int t = 0; t < tenures; t++) begin
            o = last;
            do o = (o + 1) % 4; while (!mask[o]);
            ord.push_back(o);
            for (int k = 0; k < TEN; k++) begin
                exp_q.push_back('{o, dval(o, es[o])});
                es[o]++;
            end
            last = o;
        end
        total = tenures * TEN;
        beats = 0;
        j = 0;
        while (beats < total && j < tenures * (TEN + 1) + 4) begin
            @(posedge clk); #1;
            adv();
            req = mask;
            #1;
            eg = 0;
            if ((j % (TEN + 1)) != 0 && (j / (TEN + 1)) < ord.size())
                eg = 1 << ord[j / (TEN + 1)];
            check($sformatf("%s_c%0d_gnt", tag, j), 32'(gnt), 32'(eg));
            check($sformatf("%s_c%0d_wr", tag, j), 32'(fifo_wr_en), 32'(eg != 0));
            acc = req & gnt;
            beats += $countones(acc);
            j++;
        end
        check({tag, "_beats"}, 32'(beats), 32'(total));
        @(posedge clk); #1;
        req = '0;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic run_full_hold();
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back('{2, dval(2, k)});
        for (int j = 0; j < FS_LEN; j++) begin
            @(posedge clk); #1;
            adv();
            req = (sent[2] < 4) ? 4'b0100 : 4'b0000;
            full_force = FS_FULL[j];
            #1;
            check($sformatf("hold_c%0d_gnt", j), 32'(gnt), FS_GNT[j] ? 32'h4 : 32'h0);
            check($sformatf("hold_c%0d_wr", j), 32'(fifo_wr_en), 32'(FS_GNT[j]));
            check($sformatf("hold_c%0d_busy", j), 32'(busy), 32'(FS_BUSY[j]));
            if (FS_BUSY[j]) check($sformatf("hold_c%0d_owner", j), 32'(owner), 32'h2);
            acc = req & gnt;
        end
        req = '0; full_force = 1'b0;
        check("hold_beats", 32'(sent[2]), 32'h4);
        check("hold_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic run_overflow();
        int j;
        do_reset();
        for (int k = 0; k < 64; k++) exp_q.push_back('{3, dval(3, k)});
        j = 0;
        while (fcnt < 64 && j < 64 * (TEN + 1) + 8) begin
            @(posedge clk); #1;
            adv();
            req = 4'b1000;
            #1;
            acc = req & gnt;
            j++;
        end
        check("fill_count", 32'(fcnt), 32'd64);
        check("fill_full", 32'(fifo_full), 32'h1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            adv();
            #1;
            check($sformatf("full_c%0d_gnt", c), 32'(gnt), 32'h0);
            check($sformatf("full_c%0d_wr", c), 32'(fifo_wr_en), 32'h0);
            acc = req & gnt;
        end
        req = '0;
        check("fill_drained", 32'(exp_q.size()), 32'h0);
        check("fill_no_65th", 32'(fcnt), 32'd64);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req = '0; req_data = 32'hD3C2B1A0;
        full_force = 1'b0; fifo_clr = 1'b1; acc = '0;
        for (int i = 0; i < 4; i++) sent[i] = 0;

        //   rst req   full gnt   wr    busy  own   data
        add(1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 8'hB1);
        add(1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 8'hB1);
        add(1'b1, 4'h6, 1'b0, 4'h2, 1'b1, 1'b1, 2'd1, 8'hB1);
`ifdef FIFO_ARB_BURST_LOCK_EN
        add(1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 8'hB1);
        add(1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd1, 8'h00);
        add(1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 2'd2, 8'hC2);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd2, 8'hC2);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 8'h00);
        add(1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 8'h00);
        add(1'b1, 4'h9, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 8'hD3);
        add(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 8'hD3);
        add(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 8'h00);
        add(1'b1, 4'h1, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA0);
        add(1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA0);
        add(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 8'hD3);
        add(1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 8'hA0);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA0);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
`else
        add(1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2'd1, 8'h00);
        add(1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 2'd2, 8'hC2);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 8'h00);
        add(1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 8'h00);
        add(1'b1, 4'h9, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 8'hD3);
        add(1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 8'h00);
        add(1'b1, 4'h9, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA0);
        add(1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'hA0);
        add(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 8'hD3);
        add(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 8'h00);
        add(1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0, 8'hA0);
        add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
`endif

        for (int k = 0; k < vt.size(); k++) begin
            @(posedge clk); #1;
            reset_n    = vt[k].rst;
            req        = vt[k].req;
            full_force = vt[k].full;
            if (vt[k].wr) exp_q.push_back('{int'(vt[k].own), vt[k].data});
            #1;
            check($sformatf("vec%0d_gnt", k), 32'(gnt), 32'(vt[k].gnt));
            check($sformatf("vec%0d_wr", k), 32'(fifo_wr_en), 32'(vt[k].wr));
            check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vt[k].busy));
            check($sformatf("vec%0d_owner", k), 32'(owner), 32'(vt[k].own));
            check($sformatf("vec%0d_data", k), 32'(fifo_data), 32'(vt[k].data));
        end
        @(posedge clk); #1;
        req = '0;
        check("vec_drained", 32'(exp_q.size()), 32'h0);

        run_stream(4'b0001, 8 / TEN, "single");
        check("single_fifo_count", 32'(fcnt), 32'd8);
        check("single_not_full", 32'(fifo_full), 32'h0);
        run_stream(4'b1111, 6, "all4");
        run_full_hold();
        run_overflow();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 64x8 FIFO between NREQ independent producers. Each producer presents a request with data. The arbiter grants one producer at a time and forwards that producer's data to the FIFO's `wr_en`/`data_in`. It never writes while the FIFO reports `full`. It sits between the producer blocks and the FIFO instance; the read side of the FIFO is untouched.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: data width, matches FIFO width.
- `BURST`, 4: maximum beats per tenure when burst lock is compiled in, 1..16.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; data valid while high.
- `req_data`  in  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- `gnt`  out  NREQ  one-hot grant; a beat transfers on a rising edge where `req[i] & gnt[i]`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_data`  out  DW  to FIFO `data_in`.
- `fifo_full`  in  1  from FIFO `full`.
- `owner`  out  $clog2(NREQ)  index of the current or last granted requester.
- `busy`  out  1  high while in state GRANT.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: `owner` holds the tenure.
- IDLE: if any `req` bit is high, select the first set bit searching from `last_owner+1` upward with wrap-around. Register it into `owner`, clear `beat_cnt`, and go to GRANT. If no bit is set, stay in IDLE.
- GRANT:
  - `gnt[owner] = req[owner] & !fifo_full`; all other `gnt` bits are 0.
  - `fifo_wr_en = |(req & gnt)`.
  - `fifo_data` = the `req_data` slice of `owner`, combinational mux.
  - Tenure ends and the FSM returns to IDLE when either condition holds:
    - `req[owner]` is low at the clock edge.
    - An accepted beat is the final beat of the tenure (see Configuration).
  - At tenure end, `last_owner <= owner`.
- `fifo_full` high in GRANT: `gnt` and `fifo_wr_en` are 0, the state is held, and `beat_cnt` is held. The tenure resumes when `full` falls.
- `req[owner]` low while `fifo_full` is high: the tenure ends (return to IDLE).
- `beat_cnt` is $clog2(BURST)+1 bits wide and increments only on accepted beats. It never wraps within a tenure.
- A requester may change `req_data` only after an accepted beat, or while its `req` is low.
- `fifo_wr_en` is never asserted in IDLE and never asserted while `fifo_full` is high. This is the overflow guarantee.

## Timing
- Reset values:
  - `gnt` = 0, `fifo_wr_en` = 0, `fifo_data` = 0 (IDLE mux output forced to 0), `owner` = 0, `busy` = 0.
  - State = IDLE, `beat_cnt` = 0.
  - `last_owner` = NREQ-1, so requester 0 wins first.
- Arbitration latency: `req` rising in cycle n gives `gnt` high in cycle n+1 (one IDLE cycle).
- Data path latency is 0 cycles. `fifo_data` and `fifo_wr_en` are combinational from `req`, `req_data`, `fifo_full`, and registered state.
- Each tenure is followed by exactly one IDLE bubble cycle. Maximum sustained throughput is BURST/(BURST+1) beats per cycle.
- Reset asserted mid-tenure: all outputs go to their reset values immediately, without waiting for a clock. A beat is not transferred on any edge where `reset_n` is low.

## Configuration
- Macro `FIFO_ARB_BURST_LOCK_EN`.
- Defined: a tenure lasts up to `BURST` accepted beats while `req[owner]` stays high. The final beat is the one where `beat_cnt == BURST-1`.
- Undefined: every tenure is exactly one accepted beat, so grants rotate per beat and `BURST` is ignored.
- Fairness rule is identical in both builds: round-robin from `last_owner+1`.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with all `req` high -> `gnt`=0, `fifo_wr_en`=0, `owner`=0, `busy`=0 throughout.
- Single streamer, lock on, BURST=4: requester 0 holds `req` and presents 0x01..0x08, advancing on each accepted beat -> `gnt[0]` high for 4 cycles, low for 1, high for 4. FIFO receives 0x01..0x08 in order; `full` stays 0 and `empty` clears.
- All four requesters continuously requesting, lock off -> grant order 0,1,2,3,0,1 with one IDLE cycle between grants and no requester granted twice in a row.
- `fifo_full` forced high after 2 beats of a 4-beat tenure for 3 cycles -> `gnt`=0 and `fifo_wr_en`=0 during those cycles. `owner` is unchanged, and the remaining 2 beats complete after `full` falls.
- Requester 1 drops `req` after 1 beat with requester 2 pending -> next cycle IDLE, following cycle `owner`=2 and `gnt[2]`=1.
- 64 beats written with no reads -> FIFO `full`=1 after beat 64, and no `fifo_wr_en` pulse while `full` is high. A 65th pending beat stays ungranted.
